// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default sizes for the fetch stage
package fetch_pkg;
  localparam int PC_BITS = 6;
  localparam int INSN_BITS = 16;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// pc_reg: program counter with clear, target load, increment and hold
module pc_reg #(
  parameter int W = fetch_pkg::PC_BITS
) (
  input  logic         clka,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] target,
  output logic [W-1:0] pc
);
  always_ff @(posedge clka)
    pc <= (!rst_n || clr) ? '0 : ld ? target : inc ? pc + 1'b1 : pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: INSMEM loader and program-counter/instruction-register fetch stage
module fetch_unit #(
  parameter int PC_BITS = fetch_pkg::PC_BITS,
  parameter int INSN_BITS = fetch_pkg::INSN_BITS,
  parameter logic [INSN_BITS-1:0] HALT_WORD = fetch_pkg::HALT_WORD
) (
  input  logic                 clka,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 run_start,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [INSN_BITS-1:0] load_data,
  input  logic                 load_last,
  output logic                 we_insmem,
  output logic [PC_BITS-1:0]   pc,
  output logic [INSN_BITS-1:0] instruction_in,
  input  logic [INSN_BITS-1:0] instruction_out,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PC_BITS-1:0]   branch_target,
  output logic [INSN_BITS-1:0] ir,
  output logic [PC_BITS-1:0]   ir_pc,
  output logic                 ir_valid,
  output logic                 loading,
  output logic                 halted
);
  import fetch_pkg::*;
  state_t state, state_nx;
  logic [PC_BITS-1:0] fetch_pc;
  logic fetch_valid, accept, halt_hit, run_go, pc_clr, pc_ld, pc_inc;
  assign accept = (state == LOAD) && load_valid;
  assign run_go = run_start && (state == IDLE || state == HALT);
  assign halt_hit = (state == RUN) && !stall && !branch_taken && fetch_valid && (instruction_out == HALT_WORD);
  assign pc_clr = load_start || (accept && load_last) || run_go;
  assign pc_ld = (state == RUN) && branch_taken;
  assign pc_inc = accept || ((state == RUN) && !stall && !halt_hit);
  pc_reg #(.W(PC_BITS)) u_pc_reg (
    .clka   (clka),
    .rst_n  (rst_n),
    .clr    (pc_clr),
    .ld     (pc_ld),
    .inc    (pc_inc),
    .target (branch_target),
    .pc     (pc)
  );
  always_ff @(posedge clka)
    state <= !rst_n ? IDLE : state_nx;
  always_comb
    state_nx = load_start ? LOAD :
               run_go ? RUN :
               (accept && load_last) ? IDLE :
               halt_hit ? HALT : state;
  always_comb begin
    load_ready = (state == LOAD);
    loading = (state == LOAD);
    halted = (state == HALT);
    we_insmem = accept;
    instruction_in = (state == LOAD) ? load_data : '0;
  end
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      fetch_pc <= '0;
      fetch_valid <= 1'b0;
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
    end else if (state != RUN || load_start || branch_taken) begin
      fetch_valid <= 1'b0;
      ir_valid <= 1'b0;
    end else if (!stall) begin
      fetch_pc <= pc;
      fetch_valid <= !halt_hit;
      ir <= instruction_out;
      ir_pc <= fetch_pc;
      ir_valid <= fetch_valid;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit with an INSMEM model
module tb_fetch_unit;
  logic clka = 1'b0;
  logic rst_n = 1'b0;
  logic load_start = 1'b0, run_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic stall = 1'b0, branch_taken = 1'b0;
  logic [15:0] load_data = '0;
  logic [5:0] branch_target = '0;
  logic load_ready, we_insmem, ir_valid, loading, halted;
  logic [5:0] pc, ir_pc;
  logic [15:0] instruction_in, ir;
  logic [15:0] instruction_out = '0;
  logic [15:0] mem [64];
  logic [15:0] prog [64];
  logic [15:0] wl [128];
  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clka(clka), .rst_n(rst_n), .load_start(load_start), .run_start(run_start),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .we_insmem(we_insmem), .pc(pc), .instruction_in(instruction_in), .instruction_out(instruction_out),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .loading(loading), .halted(halted)
  );

  always #5 clka = ~clka;

  always @(posedge clka) begin
    if (we_insmem) mem[pc] <= instruction_in;
    instruction_out <= mem[pc];
  end

  task automatic tick;
    @(posedge clka);
    #1;
  endtask

  function automatic logic [15:0] rand_word;
    logic [15:0] w;
    w = 16'($urandom);
    return (w == 16'hFFFF) ? 16'h0 : w;
  endfunction

  task automatic load_prog(input int n, input bit gaps);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          load_valid = 1'b0;
          #1;
          checks++;
          if (we_insmem !== 1'b0 || load_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_gap i=%0d we=%b ready=%b required we=0 ready=1", i, we_insmem, load_ready);
          end
          tick();
        end
      end
      load_valid = 1'b1;
      load_data = wl[i];
      load_last = (i == n - 1);
      #1;
      checks++;
      if (we_insmem !== 1'b1 || pc !== 6'(i) || instruction_in !== wl[i] || load_ready !== 1'b1 || loading !== 1'b1) begin
        failures++;
        $display("FAIL load_word i=%0d we=%b pc=%0d din=%h ready=%b required we=1 pc=%0d din=%h ready=1",
                 i, we_insmem, pc, instruction_in, load_ready, 6'(i), wl[i]);
      end
      prog[i % 64] = wl[i];
      tick();
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    #1;
    checks++;
    if (loading !== 1'b0 || pc !== 6'd0 || load_ready !== 1'b0 || we_insmem !== 1'b0 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_end loading=%b pc=%0d ready=%b we=%b ir_valid=%b required all 0",
               loading, pc, load_ready, we_insmem, ir_valid);
    end
    for (int i = 0; i < ((n < 64) ? n : 64); i++) begin
      checks++;
      if (mem[i] !== prog[i]) begin
        failures++;
        $display("FAIL load_mem addr=%0d got=%h required=%h", i, mem[i], prog[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({load_ready, we_insmem, loading, halted, ir_valid, pc, ir_pc, instruction_in, ir} !== '0) begin
      failures++;
      $display("FAIL reset ready=%b we=%b loading=%b halted=%b ir_valid=%b pc=%0d ir_pc=%0d din=%h ir=%h required all 0",
               load_ready, we_insmem, loading, halted, ir_valid, pc, ir_pc, instruction_in, ir);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load4;
    for (int i = 0; i < 4; i++) wl[i] = 16'(i + 1);
    load_prog(4, 1'b0);
  endtask

  task automatic test_run_halt;
    wl[0] = 16'h1111;
    wl[1] = 16'h2222;
    wl[2] = 16'hFFFF;
    load_prog(3, 1'b0);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    checks++;
    if (pc !== 6'd0 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL run_c1 pc=%0d ir_valid=%b required pc=0 ir_valid=0", pc, ir_valid);
    end
    tick();
    checks++;
    if (pc !== 6'd1 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL run_c2 pc=%0d ir_valid=%b required pc=1 ir_valid=0", pc, ir_valid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1 || ir !== wl[k] || ir_pc !== 6'(k)) begin
        failures++;
        $display("FAIL run_ir k=%0d ir=%h ir_pc=%0d valid=%b required ir=%h ir_pc=%0d valid=1",
                 k, ir, ir_pc, ir_valid, wl[k], 6'(k));
      end
    end
    checks++;
    if (halted !== 1'b1 || pc !== 6'd3) begin
      failures++;
      $display("FAIL halt_enter halted=%b pc=%0d required halted=1 pc=3", halted, pc);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (halted !== 1'b1 || pc !== 6'd3 || ir_valid !== 1'b0 || we_insmem !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold k=%0d halted=%b pc=%0d ir_valid=%b we=%b required halted=1 pc=3 ir_valid=0 we=0",
                 k, halted, pc, ir_valid, we_insmem);
      end
    end
  endtask

  task automatic test_random_run;
    logic [5:0] exp_addr, exp_pc;
    int quiet, nvalid;
    for (int i = 0; i < 64; i++) wl[i] = rand_word();
    load_prog(64, 1'b1);
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    exp_addr = 6'd0;
    exp_pc = 6'd0;
    quiet = 2;
    nvalid = 0;
    for (int c = 0; c < 300; c++) begin
      branch_taken = ($urandom_range(0, 5) == 0);
      branch_target = 6'($urandom);
      #1;
      checks++;
      if (pc !== exp_pc || we_insmem !== 1'b0) begin
        failures++;
        $display("FAIL rand_pc c=%0d pc=%0d we=%b required pc=%0d we=0", c, pc, we_insmem, exp_pc);
      end
      checks++;
      if (quiet > 0) begin
        quiet--;
        if (ir_valid !== 1'b0) begin
          failures++;
          $display("FAIL rand_bubble c=%0d ir_valid=%b required 0", c, ir_valid);
        end
      end else begin
        if (ir_valid !== 1'b1 || ir_pc !== exp_addr || ir !== prog[exp_addr]) begin
          failures++;
          $display("FAIL rand_ir c=%0d valid=%b ir_pc=%0d ir=%h required valid=1 ir_pc=%0d ir=%h",
                   c, ir_valid, ir_pc, ir, exp_addr, prog[exp_addr]);
        end
        exp_addr = exp_addr + 6'd1;
        nvalid++;
      end
      if (branch_taken) begin
        exp_pc = branch_target;
        exp_addr = branch_target;
        quiet = 2;
      end else begin
        exp_pc = exp_pc + 6'd1;
      end
      tick();
    end
    branch_taken = 1'b0;
    checks++;
    if (nvalid < 50) begin
      failures++;
      $display("FAIL rand_throughput valid_count=%0d required>=50", nvalid);
    end
  endtask

  task automatic test_stall_branch;
    int n;
    n = 0;
    while (pc !== 6'd3 && n < 80) begin
      tick();
      n++;
    end
    checks++;
    if (pc !== 6'd3) begin
      failures++;
      $display("FAIL wait_pc3 pc=%0d required 3 within 80 cycles", pc);
    end
    branch_taken = 1'b1;
    branch_target = 6'd10;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (pc !== 6'd10 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL branch_n1 pc=%0d ir_valid=%b required pc=10 ir_valid=0", pc, ir_valid);
    end
    tick();
    checks++;
    if (pc !== 6'd11 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL branch_n2 pc=%0d ir_valid=%b required pc=11 ir_valid=0", pc, ir_valid);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 6'd10 || ir !== prog[10]) begin
      failures++;
      $display("FAIL branch_n3 valid=%b ir_pc=%0d ir=%h required valid=1 ir_pc=10 ir=%h", ir_valid, ir_pc, ir, prog[10]);
    end
    tick();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (pc !== 6'd13 || ir_pc !== 6'd11 || ir !== prog[11] || ir_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold k=%0d pc=%0d ir_pc=%0d ir=%h valid=%b required pc=13 ir_pc=11 ir=%h valid=1",
                 k, pc, ir_pc, ir, ir_valid, prog[11]);
      end
      if (k == 3) begin
        branch_taken = 1'b1;
        branch_target = 6'd40;
      end
      tick();
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    checks++;
    if (pc !== 6'd40 || ir_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_branch pc=%0d ir_valid=%b required pc=40 ir_valid=0", pc, ir_valid);
    end
  endtask

  task automatic test_abort;
    tick();
    tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (loading !== 1'b1 || pc !== 6'd0 || ir_valid !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL abort loading=%b pc=%0d ir_valid=%b halted=%b required loading=1 pc=0 ir_valid=0 halted=0",
               loading, pc, ir_valid, halted);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 65; i++) wl[i] = rand_word();
    load_prog(65, 1'b0);
    checks++;
    if (mem[0] !== wl[64]) begin
      failures++;
      $display("FAIL wrap_write mem0=%h required=%h", mem[0], wl[64]);
    end
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    branch_taken = 1'b1;
    branch_target = 6'd63;
    tick();
    branch_taken = 1'b0;
    checks++;
    if (pc !== 6'd63) begin
      failures++;
      $display("FAIL wrap_pc63 pc=%0d required 63", pc);
    end
    tick();
    checks++;
    if (pc !== 6'd0) begin
      failures++;
      $display("FAIL wrap_pc0 pc=%0d required 0", pc);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 6'd63 || ir !== prog[63]) begin
      failures++;
      $display("FAIL wrap_ir63 valid=%b ir_pc=%0d ir=%h required valid=1 ir_pc=63 ir=%h", ir_valid, ir_pc, ir, prog[63]);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 6'd0 || ir !== wl[64]) begin
      failures++;
      $display("FAIL wrap_ir0 valid=%b ir_pc=%0d ir=%h required valid=1 ir_pc=0 ir=%h", ir_valid, ir_pc, ir, wl[64]);
    end
  endtask

  task automatic test_reset_mid;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data = rand_word();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({load_ready, we_insmem, loading, halted, ir_valid, pc, ir_pc, instruction_in, ir} !== '0) begin
      failures++;
      $display("FAIL reset_mid_load ready=%b we=%b loading=%b pc=%0d ir_valid=%b din=%h ir=%h required all 0",
               load_ready, we_insmem, loading, pc, ir_valid, instruction_in, ir);
    end
    load_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({load_ready, we_insmem, loading, halted, ir_valid, pc, ir_pc, instruction_in, ir} !== '0) begin
      failures++;
      $display("FAIL reset_mid_run ready=%b we=%b halted=%b pc=%0d ir_pc=%0d ir_valid=%b ir=%h required all 0",
               load_ready, we_insmem, halted, pc, ir_pc, ir_valid, ir);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      prog[i] = '0;
    end
    test_reset();
    test_load4();
    test_run_halt();
    test_random_run();
    test_stall_branch();
    test_abort();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
